// File: rtl/flit_mux_2to1.sv
`default_nettype none
// ============================================================================
// Module      : flit_mux_2to1
// Description : Registered two-input flit multiplexer for the NoC router
//               datapath. A one-hot select, sized for the router's full port
//               count, chooses which input port's {data, valid, vc} is
//               forwarded. The output is one pipeline stage. Select values
//               other than 0, bit0-only or bit1-only raise a registered
//               error flag and force an idle output.
//
// Ports       : clk       - rising-edge clock
//               rst_      - asynchronous active-low reset
//               idata_0   - flit data, port 0           (DATA_W)
//               ivalid_0  - flit valid, port 0
//               ivch_0    - virtual channel, port 0     (VCH_W)
//               idata_1   - flit data, port 1           (DATA_W)
//               ivalid_1  - flit valid, port 1
//               ivch_1    - virtual channel, port 1     (VCH_W)
//               sel       - one-hot port select         (SEL_W)
//               odata     - selected flit data, registered
//               ovalid    - selected flit valid, registered
//               ovch      - selected virtual channel, registered
//               sel_err   - registered illegal-select flag (not sticky)
//               flit_cnt  - wrapping count of valid flits forwarded (CNT_W)
//
// Revision    : 1.0 - initial release
// ============================================================================
module flit_mux_2to1 #(
   parameter int DATA_W = 64,
   parameter int VCH_W  = 2,
   parameter int SEL_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [DATA_W-1:0] idata_0,
   input  logic              ivalid_0,
   input  logic [VCH_W-1:0]  ivch_0,
   input  logic [DATA_W-1:0] idata_1,
   input  logic              ivalid_1,
   input  logic [VCH_W-1:0]  ivch_1,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid,
   output logic [VCH_W-1:0]  ovch,
   output logic              sel_err,
   output logic [CNT_W-1:0]  flit_cnt
);

   localparam logic [SEL_W-1:0] c_sel_idle  = SEL_W'(0);
   localparam logic [SEL_W-1:0] c_sel_port0 = SEL_W'(1);
   localparam logic [SEL_W-1:0] c_sel_port1 = SEL_W'(2);

   logic              w_pick_0;
   logic              w_pick_1;
   logic              w_err;
   logic [DATA_W-1:0] w_data;
   logic              w_valid;
   logic [VCH_W-1:0]  w_vch;

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic [VCH_W-1:0]  r_vch;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   // Exact compares: any multi-hot value or any bit at index >= 2 is illegal,
   // so only the three legal encodings are recognised and everything else
   // falls through to the error case.
   assign w_pick_0 = (sel == c_sel_port0);
   assign w_pick_1 = (sel == c_sel_port1);
   assign w_err    = !(w_pick_0 || w_pick_1 || (sel == c_sel_idle));

   // Next-output select. Idle and illegal selects both yield an all-zero
   // flit; the selected port is forwarded as-is even when its valid is low.
   always_comb begin
      w_data  = '0;
      w_valid = 1'b0;
      w_vch   = '0;
      if (w_pick_0) begin
         w_data  = idata_0;
         w_valid = ivalid_0;
         w_vch   = ivch_0;
      end else if (w_pick_1) begin
         w_data  = idata_1;
         w_valid = ivalid_1;
         w_vch   = ivch_1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_vch   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_data  <= w_data;
         r_valid <= w_valid;
         r_vch   <= w_vch;
         r_err   <= w_err;
         // Counts edges where the registered output becomes valid; wraps
         // naturally at 2^CNT_W.
         r_cnt   <= r_cnt + CNT_W'(w_valid);
      end
   end

   assign odata    = r_data;
   assign ovalid   = r_valid;
   assign ovch     = r_vch;
   assign sel_err  = r_err;
   assign flit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flit_mux_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_flit_mux_2to1
// Description : Directed self-checking bench for flit_mux_2to1. A second
//               instance with a 4-bit counter shares all stimulus and is used
//               to observe counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_mux_2to1;

   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic [63:0] idata_0 = '0;
   logic        ivalid_0 = 1'b0;
   logic [1:0]  ivch_0 = '0;
   logic [63:0] idata_1 = '0;
   logic        ivalid_1 = 1'b0;
   logic [1:0]  ivch_1 = '0;
   logic [4:0]  sel = '0;

   logic [63:0] odata;
   logic        ovalid;
   logic [1:0]  ovch;
   logic        sel_err;
   logic [31:0] flit_cnt;

   logic [63:0] odata_s;
   logic        ovalid_s;
   logic [1:0]  ovch_s;
   logic        sel_err_s;
   logic [3:0]  flit_cnt_s;

   int n_checks = 0;
   int n_err    = 0;
   int exp_cnt  = 0;
   logic [63:0] flit;

   always #5 clk = ~clk;

   flit_mux_2to1 dut (
      .clk(clk), .rst_(rst_),
      .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
      .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
      .sel(sel),
      .odata(odata), .ovalid(ovalid), .ovch(ovch),
      .sel_err(sel_err), .flit_cnt(flit_cnt)
   );

   flit_mux_2to1 #(.CNT_W(4)) dut_s (
      .clk(clk), .rst_(rst_),
      .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
      .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
      .sel(sel),
      .odata(odata_s), .ovalid(ovalid_s), .ovch(ovch_s),
      .sel_err(sel_err_s), .flit_cnt(flit_cnt_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [63:0] d, input logic v,
                            input logic [1:0] vc, input logic e);
      check({tag, ".odata"},   odata,          d);
      check({tag, ".ovalid"},  64'(ovalid),    64'(v));
      check({tag, ".ovch"},    64'(ovch),      64'(vc));
      check({tag, ".sel_err"}, 64'(sel_err),   64'(e));
      check({tag, ".cnt"},     64'(flit_cnt),  64'(exp_cnt));
      check({tag, ".cnt4"},    64'(flit_cnt_s), 64'(exp_cnt % 16));
   endtask

   initial begin
      // ---------------- reset ----------------
      idata_0 = 64'hFFFF_0000_1234_5678; ivalid_0 = 1'b1; ivch_0 = 2'd3;
      idata_1 = 64'h0BAD_CAFE_DEAD_BEEF; ivalid_1 = 1'b1; ivch_1 = 2'd2;
      sel = 5'b00001;
      #2 rst_ = 1'b0;
      #1;
      check_all("reset_async", 64'h0, 1'b0, 2'd0, 1'b0);
      @(posedge clk); #1;
      check_all("reset_held", 64'h0, 1'b0, 2'd0, 1'b0);
      sel = 5'b00000;
      #3 rst_ = 1'b1;
      tick();
      check_all("post_reset_idle", 64'h0, 1'b0, 2'd0, 1'b0);

      // ---------------- port 1 packet ----------------
      sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd2;
      for (int i = 0; i < 22; i++) begin
         if (i == 0)       flit = 64'hAAAA_0000_0000_0001;
         else if (i == 21) flit = 64'hFFFF_0000_0000_00FE;
         else              flit = 64'h1 << (i - 1);
         idata_1 = flit;
         idata_0 = {$urandom, $urandom}; ivalid_0 = 1'($urandom); ivch_0 = 2'($urandom);
         tick();
         exp_cnt++;
         check("p1.odata",  odata, flit);
         check("p1.ovalid", 64'(ovalid), 64'h1);
         check("p1.ovch",   64'(ovch), 64'h2);
      end
      check("p1.cnt_after_packet", 64'(flit_cnt), 64'd22);

      // ---------------- port 0 ----------------
      sel = 5'b00001; ivalid_0 = 1'b1; idata_0 = 64'h9; ivch_0 = 2'd1;
      idata_1 = 64'h5555; ivch_1 = 2'd3;
      tick(); exp_cnt++;
      check_all("p0", 64'h9, 1'b1, 2'd1, 1'b0);

      // ---------------- illegal selects ----------------
      sel = 5'b00011; ivalid_0 = 1'b1; ivalid_1 = 1'b1;
      tick();
      check_all("illegal_multihot", 64'h0, 1'b0, 2'd0, 1'b1);
      sel = 5'b10000;
      tick();
      check_all("illegal_high", 64'h0, 1'b0, 2'd0, 1'b1);
      sel = 5'b00010; idata_1 = 64'h5; ivch_1 = 2'd0;
      tick(); exp_cnt++;
      check_all("sel_back_legal", 64'h5, 1'b1, 2'd0, 1'b0);

      // ---------------- invalid gap ----------------
      ivalid_1 = 1'b0; idata_1 = 64'hAB; ivch_1 = 2'd1;
      tick();
      check_all("invalid_gap", 64'hAB, 1'b0, 2'd1, 1'b0);

      sel = 5'b00000; ivalid_1 = 1'b1;
      tick();
      check_all("idle", 64'h0, 1'b0, 2'd0, 1'b0);

      // ---------------- async reset mid-packet ----------------
      sel = 5'b00001; idata_0 = 64'h77; ivch_0 = 2'd2; ivalid_0 = 1'b1;
      tick(); exp_cnt++;
      check_all("pre_reset_flit", 64'h77, 1'b1, 2'd2, 1'b0);
      #2 rst_ = 1'b0;
      #1;
      exp_cnt = 0;
      check_all("async_reset_mid", 64'h0, 1'b0, 2'd0, 1'b0);
      #1 rst_ = 1'b1;

      // ---------------- counter wrap ----------------
      sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd3;
      for (int i = 0; i < 17; i++) begin
         idata_1 = 64'(i + 100);
         tick(); exp_cnt++;
      end
      check("wrap.cnt4", 64'(flit_cnt_s), 64'd1);
      check("wrap.cnt32", 64'(flit_cnt), 64'd17);
      check("wrap.odata4", odata_s, 64'd116);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/flit_mux_2to1.md
Name: flit_mux_2to1

Overview:
- Two-input flit multiplexer for the NoC router datapath. It forwards one of two input ports (data, valid, virtual channel) to a single output port.
- Selection uses a one-hot port-select vector sized for the router's full port count.
- The output is registered, so the block is one pipeline stage. It is also the unit used for per-flit energy characterization.

Parameters:
- DATA_W, 64, flit width in bits (type field plus payload); the content is opaque to this block.
- VCH_W, 2, virtual-channel ID width.
- SEL_W, 5, one-hot select width (router port count); only bits 0 and 1 map to inputs.
- CNT_W, 32, width of the forwarded-flit counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_  in  1  reset, asynchronous, active-low.
- idata_0  in  DATA_W  flit data, port 0.
- ivalid_0  in  1  flit valid, port 0.
- ivch_0  in  VCH_W  virtual channel, port 0.
- idata_1  in  DATA_W  flit data, port 1.
- ivalid_1  in  1  flit valid, port 1.
- ivch_1  in  VCH_W  virtual channel, port 1.
- sel  in  SEL_W  one-hot port select.
- odata  out  DATA_W  selected flit data (registered).
- ovalid  out  1  selected flit valid (registered).
- ovch  out  VCH_W  selected virtual channel (registered).
- sel_err  out  1  registered flag: select was not a legal one-hot value for this mux.
- flit_cnt  out  CNT_W  count of valid flits forwarded.

Behaviour:
- Reset (rst_=0, asynchronous): odata, ovalid, ovch, sel_err and flit_cnt go to 0 immediately and hold at 0 while reset is asserted.
- After reset is released, the first capture happens on the next rising clk edge.
- Latency is 1 cycle. The inputs and sel sampled at edge N appear on the outputs after edge N.
- Select decode, evaluated each cycle:
  - sel == 1 (bit0 only): output takes {idata_0, ivalid_0, ivch_0}.
  - sel == 2 (bit1 only): output takes {idata_1, ivalid_1, ivch_1}.
  - sel == 0: odata=0, ovalid=0, ovch=0, sel_err=0 (idle, legal).
  - Any other value (multi-hot, or any bit at index >= 2 set): odata=0, ovalid=0, ovch=0, sel_err=1.
  - sel_err is 0 in every legal case and is not sticky.
- Data, valid and VC are forwarded unconditionally for the selected port. When the selected ivalid is 0, odata and ovch still carry the selected port's values and ovalid=0. No handshake, no backpressure, no buffering.
- The unselected port has no effect on any output.
- flit_cnt:
  - Increments by 1 on each edge where the registered output becomes valid (the next ovalid is 1).
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
  - Cleared only by reset.
- A sel change takes effect on the next edge; there is no packet lock. Switching sel mid-packet switches the output mid-packet.
- Both inputs valid at once: only the selected one is forwarded; no error.
- Purely synchronous except reset; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive all inputs nonzero with rst_=0. Then outputs are all 0 with no clock running. Release rst_ and clock once with sel=0: outputs stay 0, flit_cnt=0.
- Port 1 select:
  - Stimulus: sel=5'b00010, ivalid_1=1, ivch_1=2, idata_1 = head flit, then 20 data flits with a walking-ones pattern, then a tail flit.
  - Required: each flit appears on odata with ovalid=1 and ovch=2 exactly one cycle later. flit_cnt=22 after the packet.
  - Port 0 is driven with random data throughout and never leaks to the output.
- Port 0 select: sel=5'b00001, ivalid_0=1, idata_0=64'h9, ivch_0=1 -> next cycle odata=64'h9, ovalid=1, ovch=1, sel_err=0.
- Illegal select:
  - sel=5'b00011 with both ports valid -> next cycle odata=0, ovalid=0, sel_err=1, flit_cnt unchanged.
  - sel=5'b10000 -> same response.
  - sel back to 5'b00010 -> sel_err=0 on the next cycle.
- Invalid gap: sel=2, ivalid_1=0, idata_1=64'hAB -> odata=64'hAB, ovalid=0, flit_cnt not incremented.
- Wrap and async reset:
  - With CNT_W=4, forward 17 valid flits -> flit_cnt=1 (wrapped).
  - Assert rst_ between clock edges mid-packet -> all outputs 0 immediately, before the next edge.
